// File: rtl/cpu_ctrl_pkg.sv
// Shared definitions for the multi-cycle CPU control unit: opcodes, FSM states,
// instruction classes and instruction-field positions.
package cpu_ctrl_pkg;

    localparam logic [3:0] OP_LOAD  = 4'd8;
    localparam logic [3:0] OP_STORE = 4'd9;
    localparam logic [3:0] OP_JMP   = 4'd10;
    localparam logic [3:0] OP_BRN   = 4'd11;
    localparam logic [3:0] OP_HALT  = 4'd15;

    // Low bit of each instruction field; op is 4 bits, register fields are AW bits.
    localparam int unsigned OP_LO = 12;
    localparam int unsigned RD_LO = 8;
    localparam int unsigned RS_LO = 4;
    localparam int unsigned RT_LO = 0;

    typedef enum logic [2:0] {
        StFetch = 3'd0,
        StLatch = 3'd1,
        StExec  = 3'd2,
        StLdwb  = 3'd3,
        StHalt  = 3'd4
    } state_e;

    typedef enum logic [2:0] {
        ClsAlu,
        ClsLoad,
        ClsStore,
        ClsJmp,
        ClsBrn,
        ClsNop,
        ClsHalt
    } instr_class_e;

endpackage

// File: rtl/instr_decode.sv
// Combinational instruction decoder: IR to instruction class, ALU mode and the
// register addresses the datapath needs while the instruction executes.
import cpu_ctrl_pkg::*;

module instr_decode #(
    parameter int unsigned AW = 4,
    parameter int unsigned DW = 16
) (
    input  logic [DW-1:0] ir,
    output instr_class_e  cls,
    output logic [2:0]    aluop,
    output logic [AW-1:0] ra1,
    output logic [AW-1:0] ra2,
    output logic [AW-1:0] wa
);

    logic [3:0]    op;
    logic [AW-1:0] rd;
    logic [AW-1:0] rs;
    logic [AW-1:0] rt;

    assign op = ir[OP_LO +: 4];
    assign rd = ir[RD_LO +: AW];
    assign rs = ir[RS_LO +: AW];
    assign rt = ir[RT_LO +: AW];

    always_comb begin
        cls   = ClsNop;
        aluop = '0;
        ra1   = '0;
        ra2   = '0;
        wa    = '0;
        if (!op[3]) begin
            cls   = ClsAlu;
            aluop = op[2:0];
            ra1   = rs;
            ra2   = rt;
            wa    = rd;
        end else begin
            // rd2 doubles as the memory address and the jump target
            case (op)
                OP_LOAD: begin
                    cls = ClsLoad;
                    ra2 = rs;
                    wa  = rd;
                end
                OP_STORE: begin
                    cls = ClsStore;
                    ra1 = rd;
                    ra2 = rs;
                end
                OP_JMP: begin
                    cls = ClsJmp;
                    ra2 = rs;
                end
                OP_BRN: begin
                    cls = ClsBrn;
                    ra2 = rs;
                end
                OP_HALT: cls = ClsHalt;
                default: cls = ClsNop;
            endcase
        end
    end

endmodule

// File: rtl/cpu_controller.sv
// Multi-cycle control unit for the 16-bit single-memory datapath: FETCH, LATCH,
// EXEC (+LDWB for loads), with Moore outputs decoded from state and IR.
import cpu_ctrl_pkg::*;

module cpu_controller #(
    parameter int unsigned AW = 4,
    parameter int unsigned DW = 16
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [DW-1:0] q_a,
    input  logic          neg,
    output logic          regwrite,
    output logic [AW-1:0] wa,
    output logic [AW-1:0] ra1,
    output logic [AW-1:0] ra2,
    output logic [2:0]    aluop,
    output logic          we_a,
    output logic          ld_sel,
    output logic          pc_mux,
    output logic          pc_inc,
    output logic          wr_pc,
    output logic          halted
);

    state_e        state_q, state_d;
    logic [DW-1:0] ir_q, ir_d;
    logic          nflag_q, nflag_d;

    instr_class_e  dec_cls;
    logic [2:0]    dec_aluop;
    logic [AW-1:0] dec_ra1;
    logic [AW-1:0] dec_ra2;
    logic [AW-1:0] dec_wa;

    instr_decode #(
        .AW (AW),
        .DW (DW)
    ) u_decode (
        .ir    (ir_q),
        .cls   (dec_cls),
        .aluop (dec_aluop),
        .ra1   (dec_ra1),
        .ra2   (dec_ra2),
        .wa    (dec_wa)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= StFetch;
            ir_q    <= '0;
            nflag_q <= 1'b0;
        end else begin
            state_q <= state_d;
            ir_q    <= ir_d;
            nflag_q <= nflag_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        ir_d     = ir_q;
        nflag_d  = nflag_q;
        regwrite = 1'b0;
        wa       = '0;
        ra1      = '0;
        ra2      = '0;
        aluop    = '0;
        we_a     = 1'b0;
        ld_sel   = 1'b0;
        pc_mux   = 1'b1;
        pc_inc   = 1'b0;
        wr_pc    = 1'b0;
        halted   = 1'b0;

        unique case (state_q)
            StFetch: state_d = StLatch;
            StLatch: begin
                ir_d    = q_a;
                pc_inc  = 1'b1;
                state_d = StExec;
            end
            StExec: begin
                ra1     = dec_ra1;
                ra2     = dec_ra2;
                aluop   = dec_aluop;
                state_d = StFetch;
                unique case (dec_cls)
                    ClsAlu: begin
                        regwrite = 1'b1;
                        wa       = dec_wa;
                        nflag_d  = neg;
                    end
                    ClsLoad: begin
                        pc_mux  = 1'b0;
                        state_d = StLdwb;
                    end
                    ClsStore: begin
                        pc_mux = 1'b0;
                        we_a   = 1'b1;
                    end
                    ClsJmp:  wr_pc = 1'b1;
                    // The PC already incremented in LATCH; a taken branch overwrites it.
                    ClsBrn:  wr_pc = nflag_q;
                    ClsHalt: state_d = StHalt;
                    default: ;
                endcase
            end
            StLdwb: begin
                regwrite = 1'b1;
                ld_sel   = 1'b1;
                wa       = dec_wa;
                state_d  = StFetch;
            end
            StHalt: halted = 1'b1;
            default: state_d = StFetch;
        endcase
    end

endmodule

// File: tb/tb_cpu_controller.sv
// Self-checking bench for cpu_controller: table of instructions with expected
// per-cycle outputs fed through a scoreboard queue, plus reset and HALT sequences.
module tb_cpu_controller;

    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] q_a;
    logic        neg;
    logic        regwrite;
    logic [3:0]  wa;
    logic [3:0]  ra1;
    logic [3:0]  ra2;
    logic [2:0]  aluop;
    logic        we_a;
    logic        ld_sel;
    logic        pc_mux;
    logic        pc_inc;
    logic        wr_pc;
    logic        halted;

    cpu_controller #(
        .AW (4),
        .DW (16)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .q_a      (q_a),
        .neg      (neg),
        .regwrite (regwrite),
        .wa       (wa),
        .ra1      (ra1),
        .ra2      (ra2),
        .aluop    (aluop),
        .we_a     (we_a),
        .ld_sel   (ld_sel),
        .pc_mux   (pc_mux),
        .pc_inc   (pc_inc),
        .wr_pc    (wr_pc),
        .halted   (halted)
    );

    always #5 clk = ~clk;

    // rw, wa, ra1, ra2, aluop, we_a, ld_sel, pc_mux, pc_inc, wr_pc, halted
    typedef logic [21:0] outs_t;

    typedef struct {
        string       name;
        logic [15:0] instr;
        logic        neg;
        logic        is_load;
        outs_t       exec_exp;
        outs_t       exec_care;
        outs_t       wb_exp;
        outs_t       wb_care;
    } vec_t;

    typedef struct {
        string name;
        outs_t exp;
        outs_t care;
    } sb_t;

    sb_t   sb_q[$];
    vec_t  vecs[14];
    vec_t  post_rst_brn;
    int    n_checks = 0;
    int    n_fail   = 0;
    outs_t act;

    assign act = {regwrite, wa, ra1, ra2, aluop, we_a, ld_sel, pc_mux, pc_inc, wr_pc, halted};

    function automatic outs_t mk(logic rw, logic [3:0] w, logic [3:0] r1, logic [3:0] r2,
                                 logic [2:0] op, logic we, logic ls, logic pm, logic pi,
                                 logic wp, logic h);
        return {rw, w, r1, r2, op, we, ls, pm, pi, wp, h};
    endfunction

    // Strobes are always checked; fields only where the instruction defines them.
    function automatic outs_t care(logic c_wa, logic c_r1, logic c_r2, logic c_op,
                                   logic c_ls, logic c_pm);
        return {1'b1, {4{c_wa}}, {4{c_r1}}, {4{c_r2}}, {3{c_op}}, 1'b1, c_ls, c_pm, 3'b111};
    endfunction

    outs_t rst_exp, fetch_exp, fetch_care, latch_exp, latch_care;

    task automatic check(input string nm, input outs_t exp, input outs_t cm);
        n_checks++;
        if (((act ^ exp) & cm) != '0) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (care mask %h) at %0t", nm, act, exp, cm,
                     $time);
        end
    endtask

    task automatic push(input string nm, input outs_t exp, input outs_t cm);
        sb_t e;
        e.name = nm;
        e.exp  = exp;
        e.care = cm;
        sb_q.push_back(e);
    endtask

    // Compare one queued record per cycle, starting at the current negedge.
    task automatic drain();
        sb_t e;
        while (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            check(e.name, e.exp, e.care);
            @(negedge clk);
        end
    endtask

    task automatic run_vec(input vec_t v);
        q_a = v.instr;
        neg = v.neg;
        push({v.name, "_fetch"}, fetch_exp, fetch_care);
        push({v.name, "_latch"}, latch_exp, latch_care);
        push({v.name, "_exec"}, v.exec_exp, v.exec_care);
        if (v.is_load) push({v.name, "_ldwb"}, v.wb_exp, v.wb_care);
        drain();
    endtask

    initial begin
        rst_exp    = mk(0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0);
        fetch_exp  = rst_exp;
        fetch_care = care(0, 0, 0, 0, 0, 1);
        latch_exp  = mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0);
        latch_care = care(0, 0, 0, 0, 0, 0);

        vecs[0]  = '{"add_0123", 16'h0123, 1'b0, 1'b0, mk(1, 1, 2, 3, 0, 0, 0, 0, 0, 0, 0),
                     care(1, 1, 1, 1, 1, 0), '0, '0};
        vecs[1]  = '{"sub_neg1", 16'h1456, 1'b1, 1'b0, mk(1, 4, 5, 6, 1, 0, 0, 0, 0, 0, 0),
                     care(1, 1, 1, 1, 1, 0), '0, '0};
        vecs[2]  = '{"brn_taken", 16'hB020, 1'b0, 1'b0, mk(0, 0, 0, 2, 0, 0, 0, 0, 0, 1, 0),
                     care(0, 0, 1, 0, 0, 0), '0, '0};
        vecs[3]  = '{"load_8450", 16'h8450, 1'b0, 1'b1, mk(0, 0, 0, 5, 0, 0, 0, 0, 0, 0, 0),
                     care(0, 0, 1, 0, 0, 1), mk(1, 4, 0, 0, 0, 0, 1, 0, 0, 0, 0),
                     care(1, 0, 0, 0, 1, 0)};
        vecs[4]  = '{"brn_after_load", 16'hB030, 1'b0, 1'b0,
                     mk(0, 0, 0, 3, 0, 0, 0, 0, 0, 1, 0), care(0, 0, 1, 0, 0, 0), '0, '0};
        vecs[5]  = '{"store_9670", 16'h9670, 1'b0, 1'b0, mk(0, 0, 6, 7, 0, 1, 0, 0, 0, 0, 0),
                     care(0, 1, 1, 0, 0, 1), '0, '0};
        vecs[6]  = '{"jmp_a0e0", 16'hA0E0, 1'b1, 1'b0, mk(0, 0, 0, 14, 0, 0, 0, 0, 0, 1, 0),
                     care(0, 0, 1, 0, 0, 0), '0, '0};
        vecs[7]  = '{"alu7_neg0", 16'h7FAB, 1'b0, 1'b0, mk(1, 15, 10, 11, 7, 0, 0, 0, 0, 0, 0),
                     care(1, 1, 1, 1, 1, 0), '0, '0};
        vecs[8]  = '{"brn_not_taken", 16'hB020, 1'b1, 1'b0,
                     mk(0, 0, 0, 2, 0, 0, 0, 0, 0, 0, 0), care(0, 0, 1, 0, 0, 0), '0, '0};
        vecs[9]  = '{"nop_c123", 16'hC123, 1'b1, 1'b0, mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0),
                     care(0, 0, 0, 0, 0, 0), '0, '0};
        vecs[10] = '{"alu3_neg1", 16'h3210, 1'b1, 1'b0, mk(1, 2, 1, 0, 3, 0, 0, 0, 0, 0, 0),
                     care(1, 1, 1, 1, 1, 0), '0, '0};
        vecs[11] = '{"nop_d000", 16'hD000, 1'b0, 1'b0, mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0),
                     care(0, 0, 0, 0, 0, 0), '0, '0};
        vecs[12] = '{"brn_after_nop", 16'hB0F0, 1'b0, 1'b0,
                     mk(0, 0, 0, 15, 0, 0, 0, 0, 0, 1, 0), care(0, 0, 1, 0, 0, 0), '0, '0};
        vecs[13] = '{"nop_e456", 16'hE456, 1'b1, 1'b0, mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0),
                     care(0, 0, 0, 0, 0, 0), '0, '0};
        post_rst_brn = '{"brn_post_reset", 16'hB020, 1'b1, 1'b0,
                         mk(0, 0, 0, 2, 0, 0, 0, 0, 0, 0, 0), care(0, 0, 1, 0, 0, 0), '0, '0};

        reset = 1'b1;
        q_a   = '0;
        neg   = 1'b0;
        #1 reset = 1'b0;
        @(negedge clk);
        check("reset_state", rst_exp, '1);
        @(negedge clk);
        reset = 1'b1;

        // Reset landing in the EXEC cycle of a STORE must kill we_a at once.
        q_a = 16'h9670;
        push("rst_store_fetch", fetch_exp, fetch_care);
        push("rst_store_latch", latch_exp, latch_care);
        drain();
        check("rst_store_exec", mk(0, 0, 6, 7, 0, 1, 0, 0, 0, 0, 0), care(0, 1, 1, 0, 0, 1));
        #2 reset = 1'b0;
        #1 check("store_reset_drop", rst_exp, '1);
        @(negedge clk);
        check("store_reset_hold", rst_exp, '1);
        reset = 1'b1;

        for (int i = 0; i < 14; i++) run_vec(vecs[i]);

        // HALT is absorbing: 20 cycles with no strobe while memory offers an ADD.
        q_a = 16'hF000;
        neg = 1'b1;
        push("halt_fetch", fetch_exp, fetch_care);
        push("halt_latch", latch_exp, latch_care);
        push("halt_exec", mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0),
             care(0, 0, 0, 0, 0, 0) & ~outs_t'(1));
        drain();
        q_a = 16'h0123;
        for (int i = 0; i < 20; i++) begin
            check("halted_idle", mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1), care(0, 0, 0, 0, 0, 0));
            @(negedge clk);
        end
        #2 reset = 1'b0;
        #1 check("halt_reset_clear", rst_exp, '1);
        @(negedge clk);
        reset = 1'b1;

        // nflag was 1 before the reset; it must come back as 0.
        run_vec(post_rst_brn);
        run_vec(vecs[0]);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
